// File: rtl/bomber_pkg.sv
// Shared types and default tuning for the per-player hit/flash sequencer.
//   hit_state_t          : sequencer states (idle, flashing, dead)
//   DEFAULT_FLASH_FRAMES : frames of invulnerability after an accepted hit
//   DEFAULT_BLINK_PERIOD : frames per invert half-period
//   DEFAULT_INIT_LIVES   : lives at reset / revive
//   DEFAULT_LIVES_W      : width of the lives counter
package bomber_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLASH = 2'd1,
    ST_DEAD  = 2'd2
  } hit_state_t;

  localparam int DEFAULT_FLASH_FRAMES = 120;
  localparam int DEFAULT_BLINK_PERIOD = 8;
  localparam int DEFAULT_INIT_LIVES   = 3;
  localparam int DEFAULT_LIVES_W      = 3;

endpackage

// File: rtl/frame_blink_timer.sv
// Frame counter for the invulnerability window plus the blink half-period
// counter.
//   clk, resetN : clock, asynchronous active-low reset
//   clear       : forces both counters to zero (used outside the flash window)
//   tick        : one frame elapsed (startOfFrame qualified by !pause)
//   blink_tgl   : pulse, same cycle as the tick that completes a half-period
//   done        : pulse, same cycle as the tick that completes the window
module frame_blink_timer
  import bomber_pkg::*;
#(
  parameter int FLASH_FRAMES = DEFAULT_FLASH_FRAMES,
  parameter int BLINK_PERIOD = DEFAULT_BLINK_PERIOD
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic tick,
  output logic blink_tgl,
  output logic done
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int BW = $clog2(BLINK_PERIOD + 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d, frame_inc_s;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d, blink_inc_s;
  logic          frame_hit_s, blink_hit_s;

  assign frame_inc_s = frame_cnt_q + FW'(1);
  assign blink_inc_s = blink_cnt_q + BW'(1);
  assign frame_hit_s = (frame_inc_s == FW'(FLASH_FRAMES));
  assign blink_hit_s = (blink_inc_s == BW'(BLINK_PERIOD));

  // Next-state of both counters; they clear on compare instead of wrapping.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    done        = 1'b0;
    blink_tgl   = 1'b0;
    if (clear) begin
      frame_cnt_d = '0;
      blink_cnt_d = '0;
    end else if (tick) begin
      if (frame_hit_s) begin
        // End of window wins over a coincident half-period boundary.
        frame_cnt_d = '0;
        blink_cnt_d = '0;
        done        = 1'b1;
      end else if (blink_hit_s) begin
        frame_cnt_d = frame_inc_s;
        blink_cnt_d = '0;
        blink_tgl   = 1'b1;
      end else begin
        frame_cnt_d = frame_inc_s;
        blink_cnt_d = blink_inc_s;
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
      blink_cnt_d = blink_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

endmodule

// File: rtl/player_hit_flash_ctrl.sv
// Per-player hit / invulnerability sequencer: accepts collision hits,
// blinks the sprite invert stage while invulnerable and tracks lives.
//   clk, resetN   : pixel clock, asynchronous active-low reset
//   startOfFrame  : one-cycle pulse per video frame
//   hit           : collision level, any cycle
//   pause         : freezes timers and blocks hits
//   revive        : one-cycle pulse, restart with full lives
//   invert_player : 1 = paint sprite white
//   invulnerable  : 1 while flashing
//   lives         : remaining lives
//   player_dead   : 1 once lives ran out
//   hit_ack       : one-cycle pulse per accepted hit
// All outputs are registered.
module player_hit_flash_ctrl
  import bomber_pkg::*;
#(
  parameter int FLASH_FRAMES = DEFAULT_FLASH_FRAMES,
  parameter int BLINK_PERIOD = DEFAULT_BLINK_PERIOD,
  parameter int INIT_LIVES   = DEFAULT_INIT_LIVES,
  parameter int LIVES_W      = DEFAULT_LIVES_W
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               hit,
  input  logic               pause,
  input  logic               revive,
  output logic               invert_player,
  output logic               invulnerable,
  output logic [LIVES_W-1:0] lives,
  output logic               player_dead,
  output logic               hit_ack
);

  hit_state_t         state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               invert_q, invert_d;
  logic               invul_q, invul_d;
  logic               dead_q, dead_d;
  logic               ack_q, ack_d;
  logic               tick_s, clear_s, blink_tgl_s, done_s;

  // Timers only run inside the flash window; a revive clears them at once.
  assign tick_s  = startOfFrame & ~pause;
  assign clear_s = revive | (state_q != ST_FLASH);

  frame_blink_timer #(
    .FLASH_FRAMES (FLASH_FRAMES),
    .BLINK_PERIOD (BLINK_PERIOD)
  ) u_timer (
    .clk       (clk),
    .resetN    (resetN),
    .clear     (clear_s),
    .tick      (tick_s),
    .blink_tgl (blink_tgl_s),
    .done      (done_s)
  );

  // Sequencer next-state: revive > pause > hit > frame counting.
  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    invert_d = invert_q;
    invul_d  = invul_q;
    dead_d   = dead_q;
    ack_d    = 1'b0;
    if (revive) begin
      state_d  = ST_IDLE;
      lives_d  = LIVES_W'(INIT_LIVES);
      invert_d = 1'b0;
      invul_d  = 1'b0;
      dead_d   = 1'b0;
    end else if (pause) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            if (lives_q > LIVES_W'(1)) begin
              state_d  = ST_FLASH;
              lives_d  = lives_q - LIVES_W'(1);
              ack_d    = 1'b1;
              invert_d = 1'b1;
              invul_d  = 1'b1;
            end else if (lives_q == LIVES_W'(1)) begin
              state_d = ST_DEAD;
              lives_d = '0;
              ack_d   = 1'b1;
              dead_d  = 1'b1;
            end else begin
              // No lives left but not yet marked dead: settle there quietly.
              state_d = ST_DEAD;
              dead_d  = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FLASH: begin
          if (done_s) begin
            state_d  = ST_IDLE;
            invert_d = 1'b0;
            invul_d  = 1'b0;
          end else if (blink_tgl_s) begin
            invert_d = ~invert_q;
          end else begin
            invert_d = invert_q;
          end
        end
        ST_DEAD: begin
          dead_d   = 1'b1;
          invert_d = 1'b0;
          invul_d  = 1'b0;
        end
        default: begin
          state_d  = ST_IDLE;
          invert_d = 1'b0;
          invul_d  = 1'b0;
          dead_d   = 1'b0;
        end
      endcase
    end
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= ST_IDLE;
      lives_q  <= LIVES_W'(INIT_LIVES);
      invert_q <= 1'b0;
      invul_q  <= 1'b0;
      dead_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      invert_q <= invert_d;
      invul_q  <= invul_d;
      dead_q   <= dead_d;
      ack_q    <= ack_d;
    end
  end

  assign invert_player = invert_q;
  assign invulnerable  = invul_q;
  assign lives         = lives_q;
  assign player_dead   = dead_q;
  assign hit_ack       = ack_q;

endmodule

// File: tb/tb_player_hit_flash_ctrl.sv
// Directed bench for player_hit_flash_ctrl with FLASH_FRAMES=6,
// BLINK_PERIOD=2, INIT_LIVES=3.
module tb_player_hit_flash_ctrl;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       hit = 1'b0;
  logic       pause = 1'b0;
  logic       revive = 1'b0;
  logic       invert_player;
  logic       invulnerable;
  logic [2:0] lives;
  logic       player_dead;
  logic       hit_ack;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int ack_seen;

  always #5 clk = ~clk;

  player_hit_flash_ctrl #(
    .FLASH_FRAMES (6),
    .BLINK_PERIOD (2),
    .INIT_LIVES   (3),
    .LIVES_W      (3)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .hit           (hit),
    .pause         (pause),
    .revive        (revive),
    .invert_player (invert_player),
    .invulnerable  (invulnerable),
    .lives         (lives),
    .player_dead   (player_dead),
    .hit_ack       (hit_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle so registered outputs can be sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n frame pulses, each followed by an idle cycle.
  task automatic sof(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      step();
    end
  endtask

  task automatic single_hit();
    hit = 1'b1;
    step();
    hit = 1'b0;
  endtask

  initial begin
    // 1: reset
    step();
    check("rst_async_lives", lives, 3);
    resetN = 1'b1;
    step();
    check("rst_lives", lives, 3);
    check("rst_invert", invert_player, 0);
    check("rst_invul", invulnerable, 0);
    check("rst_dead", player_dead, 0);
    check("rst_ack", hit_ack, 0);

    // 2: hit in IDLE, then blink pattern
    single_hit();
    check("hit_ack", hit_ack, 1);
    check("hit_lives", lives, 2);
    check("hit_invert", invert_player, 1);
    check("hit_invul", invulnerable, 1);
    step();
    check("ack_pulse", hit_ack, 0);
    sof(1);
    check("sof1_invert", invert_player, 1);
    sof(1);
    check("sof2_invert", invert_player, 0);
    sof(1);
    check("sof3_invert", invert_player, 0);

    // 3: hit held mid-flash is ignored
    ack_seen = 0;
    hit = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (hit_ack) ack_seen = 1;
    end
    hit = 1'b0;
    check("held_hit_ack", ack_seen, 0);
    check("held_hit_lives", lives, 2);
    sof(1);
    check("sof4_invert", invert_player, 1);
    sof(1);
    check("sof5_invul", invulnerable, 1);
    sof(1);
    check("sof6_invert", invert_player, 0);
    check("sof6_invul", invulnerable, 0);

    // 4: lives run out
    revive = 1'b1;
    step();
    revive = 1'b0;
    check("revive_lives", lives, 3);
    single_hit();
    check("h1_lives", lives, 2);
    check("h1_ack", hit_ack, 1);
    sof(5);
    // hit held across the expiry edge: ignored on that edge, taken next
    startOfFrame = 1'b1;
    hit = 1'b1;
    step();
    startOfFrame = 1'b0;
    check("expiry_edge_ack", hit_ack, 0);
    check("expiry_edge_invul", invulnerable, 0);
    step();
    hit = 1'b0;
    check("h2_ack", hit_ack, 1);
    check("h2_lives", lives, 1);
    check("h2_invert", invert_player, 1);
    sof(6);
    check("h2_end_invul", invulnerable, 0);
    single_hit();
    check("h3_ack", hit_ack, 1);
    check("h3_lives", lives, 0);
    check("h3_dead", player_dead, 1);
    check("h3_invert", invert_player, 0);
    check("h3_invul", invulnerable, 0);
    step();
    single_hit();
    check("h4_ack", hit_ack, 0);
    check("h4_lives", lives, 0);
    revive = 1'b1;
    step();
    revive = 1'b0;
    check("revive2_lives", lives, 3);
    check("revive2_dead", player_dead, 0);

    // 5: hit with coincident SOF (not counted), pause freezes the window
    hit = 1'b1;
    startOfFrame = 1'b1;
    step();
    hit = 1'b0;
    startOfFrame = 1'b0;
    check("p_ack", hit_ack, 1);
    check("p_lives", lives, 2);
    sof(3);
    check("p_sof3_invert", invert_player, 0);
    pause = 1'b1;
    hit = 1'b1;
    sof(10);
    hit = 1'b0;
    check("p_frozen_invert", invert_player, 0);
    check("p_frozen_invul", invulnerable, 1);
    check("p_lives_hold", lives, 2);
    pause = 1'b0;
    sof(1);
    check("p_u1_invert", invert_player, 1);
    sof(1);
    check("p_u2_invul", invulnerable, 1);
    sof(1);
    check("p_u3_invul", invulnerable, 0);
    check("p_u3_invert", invert_player, 0);
    pause = 1'b1;
    single_hit();
    pause = 1'b0;
    check("p_idle_ack", hit_ack, 0);
    check("p_idle_lives", lives, 2);

    // 6: async reset mid-flash, then revive beats hit
    single_hit();
    check("r_lives", lives, 1);
    sof(1);
    #2;
    resetN = 1'b0;
    #1;
    check("r_async_lives", lives, 3);
    check("r_async_invert", invert_player, 0);
    check("r_async_invul", invulnerable, 0);
    step();
    resetN = 1'b1;
    step();
    revive = 1'b1;
    hit = 1'b1;
    step();
    revive = 1'b0;
    hit = 1'b0;
    check("rv_ack", hit_ack, 0);
    check("rv_lives", lives, 3);
    check("rv_invul", invulnerable, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
